riscv_lsu_wb: RTL and testbench
===============================

# riscv_lsu_wb

Load/store sequencer between the execute stage and the data-memory port, and the producer of register-file write port B. It accepts one memory operation at a time and runs the OBI-style req/gnt/rvalid handshake. Misaligned accesses are split into two word accesses. Load data is aligned and sign/zero-extended, then written back with a single-cycle write-enable pulse on port B (waddr_b/wdata_b/we_b).

## Interface
- ADDR_WIDTH, 6, register-file address width; bit 5 selects the FP bank, forwarded unchanged.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  1  operation valid from execute stage.
- ready_o  out  1  block idle and able to accept; handshake completes on req_i && ready_o at a rising edge.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- sign_ext_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, LSB-aligned.
- rd_i  in  ADDR_WIDTH  load destination register.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  memory grant.
- data_addr_o  out  32  word-aligned address, bits [1:0] = 00.
- data_we_o  out  1  store.
- data_be_o  out  4  byte enables.
- data_wdata_o  out  32  lane-aligned store data.
- data_rvalid_i  in  1  response valid.
- data_rdata_i  in  32  read data.
- rf_we_o  out  1  to we_b_i.
- rf_waddr_o  out  ADDR_WIDTH  to waddr_b_i.
- rf_wdata_o  out  32  to wdata_b_i.
- misaligned_o  out  1  high while the current operation needs two accesses.

## Operation
- FSM states:
  - IDLE: ready_o = 1.
  - REQ1: data_req_o = 1.
  - WAIT1.
  - REQ2: data_req_o = 1.
  - WAIT2.
- Transitions:
  - IDLE → REQ1 on accept; the operation is captured into registers.
  - REQ1 → WAIT1 on data_gnt_i.
  - WAIT1 → REQ2 on data_rvalid_i if misaligned, else → IDLE.
  - REQ2 → WAIT2 on data_gnt_i.
  - WAIT2 → IDLE on data_rvalid_i.
- Let off = addr[1:0]. Misaligned = (half and off = 3) or (word and off ≠ 0).
- Phase 1 address = addr & ~3; phase 2 address = phase 1 address + 4, wrapping at 2^32.
- Byte enables:
  - Byte: 1 << off.
  - Half, aligned: 0011 << off.
  - Half, off = 3: phase 1 = 1000, phase 2 = 0001.
  - Word: phase 1 = (1111 << off)[3:0]; phase 2 = 1111 >> (4 − off).
- data_wdata_o = wdata rotated left by 8·off in both phases.
- Load data:
  - Phase-1 rdata is held in a register.
  - Aligned: word = rdata >> 8·off.
  - Misaligned: word = ({rdata2, rdata1} >> 8·off)[31:0].
  - Then extract byte/half/word and extend per sign_ext_i.
- Writeback:
  - On the final rvalid of a load, rf_we_o, rf_waddr_o = rd and rf_wdata_o are registered.
  - rf_we_o is high for exactly one cycle; rd = 0 is still written, and the register file discards it.
  - Stores never assert rf_we_o.
- Ignored inputs:
  - data_gnt_i outside REQx.
  - data_rvalid_i outside WAITx.
  - req_i while ready_o = 0.

## Timing
- Reset values: all outputs 0 except ready_o = 1; state IDLE.
- data_req_o, data_addr_o, data_be_o, data_we_o and data_wdata_o are registered and held stable from request assertion until the grant edge.
- Aligned load, zero wait:
  - Accept at edge E0; data_req_o is high in cycle E0+1.
  - Grant is sampled at E1; rvalid is sampled at E2.
  - rf_we_o and ready_o are high in the cycle after E2.
  - Accept-to-writeback is 3 cycles.
- Misaligned access adds 2 cycles; data_req_o for phase 2 rises in the cycle after the phase-1 rvalid.
- Each wait cycle on gnt or rvalid adds one cycle; there is no timeout.
- A new operation can be accepted in the same cycle that rf_we_o pulses, so the issue rate is one aligned access per 3 cycles.
- Reset mid-operation: immediate return to IDLE, outputs to reset values, no writeback. A late rvalid after reset is ignored.

## Test plan
- Aligned LW, addr 0x100, rdata 0xDEADBEEF, rd 5, zero-wait memory → data_addr 0x100, be 1111; rf_we pulse with waddr 5, wdata 0xDEADBEEF, 3 cycles after accept.
- LB signed at addr 0x203 with rdata 0x80_00_00_00, then LBU at the same address → rf_wdata 0xFFFFFF80 for LB, then 0x00000080 for LBU.
- Misaligned LW at addr 0x102, rdata1 0x3344_xxxx, rdata2 0xxxxx_1122 → two requests: 0x100 with be 1100, then 0x104 with be 0011; rf_wdata 0x11223344; misaligned_o high throughout.
- SH at addr 0x7 with wdata 0xABCD → phase 1: addr 0x4, be 1000, wdata[31:24] = 0xCD; phase 2: addr 0x8, be 0001, wdata[7:0] = 0xAB; no rf_we.
- Grant stalled 4 cycles, with a spurious rvalid during REQ1 → address and be held stable throughout, spurious rvalid ignored, writeback delayed by exactly 4 cycles.
- rst_n low while in WAIT1, then rvalid arrives after reset → no rf_we, ready_o = 1, next accept behaves normally.

Source files
------------

// File: rtl/riscv_lsu_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// riscv_lsu_wb : load/store sequencer (OBI req/gnt/rvalid) with RF port-B writeback
// Revision 1.0
// ============================================================================
module riscv_lsu_wb #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  ready_o,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_ext_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [31:0]           rf_wdata_o,
  output logic                  misaligned_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_REQ2  = 3'd3,
    S_WAIT2 = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic                  we_q, sign_q, mis_q;
  logic [1:0]            size_q, off_q;
  logic [3:0]            be2_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [31:0]           rdata1_q;
  logic                  data_req_q, data_we_q;
  logic [31:0]           data_addr_q, data_wdata_q;
  logic [3:0]            data_be_q;
  logic                  rf_we_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [31:0]           rf_wdata_q;

  logic        accept, final_rv, mis_in;
  logic [1:0]  off_in;
  logic [4:0]  sh_in;
  logic [7:0]  be_span, be_in;
  logic [31:0] wdata_rot;
  logic [31:0] ld_lo, ld_word, ld_ext;
  logic [23:0] ld_hi;
  logic [55:0] ld_cat;

  assign accept   = req_i && (state_q == S_IDLE);
  assign final_rv = data_rvalid_i &&
                    (((state_q == S_WAIT1) && !mis_q) || (state_q == S_WAIT2));

  assign off_in  = addr_i[1:0];
  assign sh_in   = {off_in, 3'b000};
  assign mis_in  = ((size_i == 2'b01) && (off_in == 2'd3)) ||
                   (size_i[1] && (off_in != 2'd0));

  // Upper nibble of the shifted span is the phase-2 enable set.
  always_comb begin
    be_span = 8'h0F;
    case (size_i)
      2'b00:   be_span = 8'h01;
      2'b01:   be_span = 8'h03;
      default: be_span = 8'h0F;
    endcase
  end
  assign be_in     = be_span << off_in;
  assign wdata_rot = (wdata_i << sh_in) | (wdata_i >> (6'd32 - {1'b0, sh_in}));

  assign ld_lo  = mis_q ? rdata1_q : data_rdata_i;
  assign ld_hi  = mis_q ? data_rdata_i[23:0] : 24'h0;
  assign ld_cat = {ld_hi, ld_lo};

  always_comb begin
    ld_word = ld_cat[31:0];
    case (off_q)
      2'd0: ld_word = ld_cat[31:0];
      2'd1: ld_word = ld_cat[39:8];
      2'd2: ld_word = ld_cat[47:16];
      2'd3: ld_word = ld_cat[55:24];
      default: ld_word = ld_cat[31:0];
    endcase
  end

  always_comb begin
    ld_ext = ld_word;
    case (size_q)
      2'b00:   ld_ext = {{24{sign_q & ld_word[7]}},  ld_word[7:0]};
      2'b01:   ld_ext = {{16{sign_q & ld_word[15]}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_i)         state_d = S_REQ1;
      S_REQ1:  if (data_gnt_i)    state_d = S_WAIT1;
      S_WAIT1: if (data_rvalid_i) state_d = mis_q ? S_REQ2 : S_IDLE;
      S_REQ2:  if (data_gnt_i)    state_d = S_WAIT2;
      S_WAIT2: if (data_rvalid_i) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      sign_q       <= 1'b0;
      mis_q        <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      be2_q        <= 4'h0;
      rd_q         <= '0;
      rdata1_q     <= 32'h0;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_addr_q  <= 32'h0;
      data_wdata_q <= 32'h0;
      data_be_q    <= 4'h0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= 32'h0;
    end else begin
      rf_we_q <= 1'b0;
      if (accept) begin
        we_q         <= we_i;
        sign_q       <= sign_ext_i;
        mis_q        <= mis_in;
        size_q       <= size_i;
        off_q        <= off_in;
        be2_q        <= be_in[7:4];
        rd_q         <= rd_i;
        data_req_q   <= 1'b1;
        data_we_q    <= we_i;
        data_addr_q  <= {addr_i[31:2], 2'b00};
        data_be_q    <= be_in[3:0];
        data_wdata_q <= wdata_rot;
      end
      if (((state_q == S_REQ1) || (state_q == S_REQ2)) && data_gnt_i)
        data_req_q <= 1'b0;
      if ((state_q == S_WAIT1) && data_rvalid_i) begin
        rdata1_q <= data_rdata_i;
        if (mis_q) begin
          data_req_q  <= 1'b1;
          data_addr_q <= data_addr_q + 32'd4;
          data_be_q   <= be2_q;
        end
      end
      if (final_rv) begin
        mis_q <= 1'b0;
        if (!we_q) begin
          rf_we_q    <= 1'b1;
          rf_waddr_q <= rd_q;
          rf_wdata_q <= ld_ext;
        end
      end
    end
  end

  assign ready_o      = (state_q == S_IDLE);
  assign data_req_o   = data_req_q;
  assign data_addr_o  = data_addr_q;
  assign data_we_o    = data_we_q;
  assign data_be_o    = data_be_q;
  assign data_wdata_o = data_wdata_q;
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign misaligned_o = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_riscv_lsu_wb : directed scoreboard bench for riscv_lsu_wb
// Revision 1.0
// ============================================================================
module tb_riscv_lsu_wb;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_i = 1'b0, we_i = 1'b0, sign_ext_i = 1'b0;
  logic [1:0]    size_i = 2'b00;
  logic [31:0]   addr_i = 32'h0, wdata_i = 32'h0;
  logic [AW-1:0] rd_i = '0;
  logic          ready_o, data_req_o, data_we_o, rf_we_o, misaligned_o;
  logic          data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
  logic [31:0]   data_addr_o, data_wdata_o, rf_wdata_o;
  logic [31:0]   data_rdata_i = 32'h0;
  logic [3:0]    data_be_o;
  logic [AW-1:0] rf_waddr_o;

  always #5 clk = ~clk;

  riscv_lsu_wb #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .ready_o(ready_o), .we_i(we_i),
    .size_i(size_i), .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rd_i(rd_i), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .misaligned_o(misaligned_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        mis;
  } req_t;

  typedef struct {
    logic [AW-1:0] rd;
    logic [31:0]   data;
    int            acc;
    int            lat;
  } wb_t;

  req_t        reqq[$];
  wb_t         wbq[$];
  logic [31:0] rdq[$];

  int checks = 0, errors = 0, cyc = 0;
  int gnt_stall = 0;
  bit spur = 1'b0, hold_rv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: optional grant stall, optional spurious rvalid while stalled,
  // and rvalid one cycle after grant unless held back.
  initial begin
    bit rv_pending = 1'b0;
    int stall = 0;
    forever begin
      @(posedge clk); #1;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
      if (rv_pending && !hold_rv) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
        rv_pending    = 1'b0;
      end else if (data_req_o && rst_n) begin
        if (stall < gnt_stall) begin
          stall++;
          if (spur && stall == 2) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = 32'hBAD0BAD0;
          end
        end else begin
          data_gnt_i = 1'b1;
          stall      = 0;
          rv_pending = 1'b1;
        end
      end
    end
  end

  // Monitor: every request cycle is compared against the head of the request
  // queue (so stalls also check stability); head pops on grant.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (data_req_o) begin
        if (reqq.size() == 0) begin
          chk("req_unexpected", 32'h1, 32'h0);
        end else begin
          chk("req_addr", data_addr_o, reqq[0].addr);
          chk("req_be", {28'h0, data_be_o}, {28'h0, reqq[0].be});
          chk("req_we", {31'h0, data_we_o}, {31'h0, reqq[0].we});
          chk("req_mis", {31'h0, misaligned_o}, {31'h0, reqq[0].mis});
          if (reqq[0].we) chk("req_wdata", data_wdata_o, reqq[0].wdata);
          if (data_gnt_i) void'(reqq.pop_front());
        end
      end
      if (rf_we_o) begin
        if (wbq.size() == 0) begin
          chk("wb_unexpected", 32'h1, 32'h0);
        end else begin
          wb_t w;
          w = wbq.pop_front();
          chk("wb_waddr", {26'h0, rf_waddr_o}, {26'h0, w.rd});
          chk("wb_wdata", rf_wdata_o, w.data);
          chk("wb_latency", cyc - w.acc + 1, w.lat);
          chk("wb_ready", {31'h0, ready_o}, 32'h1);
        end
      end
    end
  end

  task automatic xreq(input logic [31:0] a, input logic [3:0] be, input logic wr,
                      input logic [31:0] wd, input logic mis);
    req_t r;
    r.addr = a; r.be = be; r.we = wr; r.wdata = wd; r.mis = mis;
    reqq.push_back(r);
  endtask

  task automatic op(input logic wr, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] wd, input logic [AW-1:0] rd,
                    input logic [31:0] exp_wb, input int lat, input bit has_wb);
    int n = 0;
    wb_t w;
    while (!ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) begin
      chk("ready_timeout", 32'h0, 32'h1);
      return;
    end
    req_i = 1'b1; we_i = wr; size_i = sz; sign_ext_i = sx;
    addr_i = a; wdata_i = wd; rd_i = rd;
    @(posedge clk); #1;
    req_i = 1'b0;
    if (has_wb) begin
      w.rd = rd; w.data = exp_wb; w.acc = cyc; w.lat = lat;
      wbq.push_back(w);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ready_o && reqq.size() == 0 && wbq.size() == 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, ready_o}, 32'h1);
    chk("rst_req", {31'h0, data_req_o}, 32'h0);
    chk("rst_rf_we", {31'h0, rf_we_o}, 32'h0);
    chk("rst_mis", {31'h0, misaligned_o}, 32'h0);
    chk("rst_addr", data_addr_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned LW
    xreq(32'h100, 4'hF, 1'b0, 32'h0, 1'b0); rdq.push_back(32'hDEADBEEF);
    op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 6'd5, 32'hDEADBEEF, 3, 1'b1);
    // LB signed then LBU at 0x203
    xreq(32'h200, 4'b1000, 1'b0, 32'h0, 1'b0); rdq.push_back(32'h80000000);
    op(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 6'd7, 32'hFFFFFF80, 3, 1'b1);
    xreq(32'h200, 4'b1000, 1'b0, 32'h0, 1'b0); rdq.push_back(32'h80000000);
    op(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 6'd8, 32'h00000080, 3, 1'b1);
    // Misaligned LW at 0x102
    xreq(32'h100, 4'b1100, 1'b0, 32'h0, 1'b1); rdq.push_back(32'h3344AAAA);
    xreq(32'h104, 4'b0011, 1'b0, 32'h0, 1'b1); rdq.push_back(32'h55661122);
    op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 6'd9, 32'h11223344, 5, 1'b1);
    // Misaligned SH at 0x7
    xreq(32'h4, 4'b1000, 1'b1, 32'hCD0000AB, 1'b1); rdq.push_back(32'h0);
    xreq(32'h8, 4'b0001, 1'b1, 32'hCD0000AB, 1'b1); rdq.push_back(32'h0);
    op(1'b1, 2'b01, 1'b0, 32'h7, 32'h0000ABCD, 6'd0, 32'h0, 0, 1'b0);
    // Aligned SW
    xreq(32'h10, 4'hF, 1'b1, 32'h11223344, 1'b0); rdq.push_back(32'h0);
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 6'd0, 32'h0, 0, 1'b0);
    // LHU at off 3 (split half)
    xreq(32'h10, 4'b1000, 1'b0, 32'h0, 1'b1); rdq.push_back(32'hAB000000);
    xreq(32'h14, 4'b0001, 1'b0, 32'h0, 1'b1); rdq.push_back(32'h000000CD);
    op(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 6'd12, 32'h0000CDAB, 5, 1'b1);
    // Size 11 word, wrapping second address, rd 0 still written
    xreq(32'hFFFFFFFC, 4'b1100, 1'b0, 32'h0, 1'b1); rdq.push_back(32'h22110000);
    xreq(32'h00000000, 4'b0011, 1'b0, 32'h0, 1'b1); rdq.push_back(32'h00004433);
    op(1'b0, 2'b11, 1'b1, 32'hFFFFFFFE, 32'h0, 6'd0, 32'h44332211, 5, 1'b1);

    // Grant stalled 4 cycles with spurious rvalid
    wait_idle();
    gnt_stall = 4; spur = 1'b1;
    xreq(32'h300, 4'hF, 1'b0, 32'h0, 1'b0); rdq.push_back(32'h12345678);
    op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 6'd3, 32'h12345678, 7, 1'b1);
    wait_idle();
    gnt_stall = 0; spur = 1'b0;

    // Reset while waiting for rvalid; the late rvalid must not write back
    hold_rv = 1'b1;
    xreq(32'h400, 4'hF, 1'b0, 32'h0, 1'b0); rdq.push_back(32'hFFFFFFFF);
    op(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 6'd10, 32'h0, 0, 1'b0);
    n = 0;
    while (reqq.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_test_granted", reqq.size(), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, ready_o}, 32'h1);
    chk("midrst_rf_we", {31'h0, rf_we_o}, 32'h0);
    chk("midrst_req", {31'h0, data_req_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_rv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_ready", {31'h0, ready_o}, 32'h1);
    chk("postrst_rf_we", {31'h0, rf_we_o}, 32'h0);

    // Normal LH signed after reset
    xreq(32'h400, 4'b1100, 1'b0, 32'h0, 1'b0); rdq.push_back(32'h80010000);
    op(1'b0, 2'b01, 1'b1, 32'h402, 32'h0, 6'd11, 32'hFFFF8001, 3, 1'b1);

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("end_req_queue", reqq.size(), 32'h0);
    chk("end_wb_queue", wbq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
